// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multiply/divide sequencer.
// MD_WIDTH sets the datapath width; the helper functions are sized from it.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef logic [MD_WIDTH-1:0]   md_word_t;
  typedef logic [2*MD_WIDTH-1:0] md_dword_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  // Two's complement negation of a single word.
  function automatic md_word_t twos_neg(input md_word_t x);
    return ~x + 1'b1;
  endfunction

  // Two's complement negation of a double word (full product).
  function automatic md_dword_t twos_neg_wide(input md_dword_t x);
    return ~x + 1'b1;
  endfunction

  // Magnitude of a signed operand; unsigned operands pass through untouched.
  // INT_MIN maps onto itself, which reads correctly as an unsigned magnitude.
  function automatic md_word_t abs_if_signed(input md_word_t x, input logic uns);
    return (!uns && x[MD_WIDTH-1]) ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with the HI/LO register pair.
// Works on operand magnitudes (shift-add multiply, restoring divide), then
// applies the sign fixup and commits HI/LO one cycle after the last iteration.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | waiting for start; mthi/mtlo accepted here only
//  CALC  | one multiply or divide iteration per clock, counter counts down
//  FIXUP | sign correction / divide-by-zero result, HI/LO commit, done next
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mul,
  input  logic             uns,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_mul_q;
  logic               div_zero_q;
  logic               neg_q_q;    // negate quotient / product (signed ops only)
  logic               neg_r_q;    // negate remainder (signed ops only)
  logic [WIDTH-1:0]   opnd_q;     // multiplicand for mul, divisor for div
  logic [WIDTH-1:0]   a_raw_q;    // dividend as issued, for divide by zero
  logic [WIDTH:0]     acc_hi_q;   // mul high half / div remainder, carry bit on top
  logic [WIDTH-1:0]   acc_lo_q;   // mul low half+multiplier / div quotient
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_hi_d;
  logic [WIDTH-1:0]   mul_lo_d;
  logic [WIDTH:0]     div_hi_d;
  logic [WIDTH-1:0]   div_lo_d;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Operand magnitudes presented at launch.
  always_comb begin
    a_mag = abs_if_signed(op_a, uns);
    b_mag = abs_if_signed(op_b, uns);
  end

  // Shift-add multiply step: conditional add into the high half, then shift right.
  always_comb begin
    logic [WIDTH:0] sum;
    sum = acc_lo_q[0] ? (acc_hi_q + {1'b0, opnd_q}) : acc_hi_q;
    mul_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
    mul_hi_d = {1'b0, sum[WIDTH:1]};
  end

  // Restoring divide step: shift in the next dividend bit, keep the trial if non-negative.
  always_comb begin
    logic [WIDTH:0] rem_sh;
    logic           fits;
    rem_sh   = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
    fits     = (rem_sh >= {1'b0, opnd_q});
    div_hi_d = fits ? (rem_sh - {1'b0, opnd_q}) : rem_sh;
    div_lo_d = {acc_lo_q[WIDTH-2:0], fits};
  end

  // Final HI/LO values: sign fixup, or the fixed divide-by-zero pattern.
  always_comb begin
    md_dword_t prod;
    prod   = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    fix_hi = acc_hi_q[WIDTH-1:0];
    fix_lo = acc_lo_q;
    if (is_mul_q) begin
      if (neg_q_q) begin
        {fix_hi, fix_lo} = twos_neg_wide(prod);
      end
    end else if (div_zero_q) begin
      fix_hi = a_raw_q;
      fix_lo = '1;
    end else begin
      if (neg_q_q) fix_lo = twos_neg(acc_lo_q);
      if (neg_r_q) fix_hi = twos_neg(acc_hi_q[WIDTH-1:0]);
    end
  end

  // Sequencer state, iteration registers and the HI/LO pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_mul_q   <= 1'b0;
      div_zero_q <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_mul_q   <= mul;
            div_zero_q <= (op_b == '0);
            neg_q_q    <= !uns && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_r_q    <= !uns && op_a[WIDTH-1];
            a_raw_q    <= op_a;
            acc_hi_q   <= '0;
            cnt_q      <= CNT_W'(WIDTH - 1);
            if (mul) begin
              opnd_q   <= a_mag;
              acc_lo_q <= b_mag;
            end else begin
              opnd_q   <= b_mag;
              acc_lo_q <= a_mag;
            end
            state_q <= CALC;
          end else begin
            if (mthi) hi_q <= op_a;
            if (mtlo) lo_q <= op_a;
          end
        end
        CALC: begin
          if (is_mul_q) begin
            acc_hi_q <= mul_hi_d;
            acc_lo_q <= mul_lo_d;
          end else begin
            acc_hi_q <= div_hi_d;
            acc_lo_q <= div_lo_d;
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= FIXUP;
        end
        FIXUP: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule
